// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter and sequences instruction fetch.
//
// Each FETCH cycle the next PC is chosen in priority order: halt, redirect
// (jump / relative branch / call / return), stall, accepted fetch
// (increment), otherwise hold. Calls and returns go through a small circular
// return-address stack.
//
// Ports:
//   clock           rising-edge clock
//   reset_n         asynchronous active-low reset
//   imem_req        fetch request valid (FETCH state and not stalled)
//   imem_addr       fetch address, equal to the current PC
//   imem_ready      instruction memory accepts the request this cycle
//   stall           hold PC and suppress new requests
//   redirect_valid  change of flow this cycle
//   redirect_kind   00 jump, 01 relative branch, 10 call, 11 return
//   redirect_target absolute target, or signed offset for a branch
//   halt            stop fetching until reset
//   pc_out          address of the fetch accepted in the previous cycle
//   pc_valid        one-cycle pulse qualifying pc_out
//   ras_overflow    sticky: a call overwrote the oldest RAS entry
//   ras_underflow   sticky: a return popped an empty RAS

module pc_sequencer #(
    parameter int unsigned              ADDR_W     = 12,
    parameter logic [ADDR_W-1:0]        RESET_ADDR = '0,
    parameter int unsigned              RAS_DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [1:0]        redirect_kind,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              halt,
    output logic [ADDR_W-1:0] pc_out,
    output logic              pc_valid,
    output logic              ras_overflow,
    output logic              ras_underflow
);

    localparam int unsigned SP_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    localparam logic [1:0] KIND_JUMP   = 2'b00;
    localparam logic [1:0] KIND_BRANCH = 2'b01;
    localparam logic [1:0] KIND_CALL   = 2'b10;
    localparam logic [1:0] KIND_RETURN = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // Registered state
    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   r_pc_out;
    logic                r_pc_valid;
    logic                r_ras_overflow;
    logic                r_ras_underflow;
    logic [ADDR_W-1:0]   r_ras [RAS_DEPTH];
    logic [SP_W-1:0]     r_sp;     // next slot to write; top of stack is r_sp-1
    logic [CNT_W-1:0]    r_cnt;    // number of live entries, saturates at RAS_DEPTH

    // Next-state values
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic [ADDR_W-1:0]   w_pc_out_nxt;
    logic                w_pc_valid_nxt;
    logic                w_ras_overflow_nxt;
    logic                w_ras_underflow_nxt;
    logic [SP_W-1:0]     w_sp_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_push;

    // Helpers
    logic                w_accept;
    logic [ADDR_W-1:0]   w_pc_inc;
    logic [SP_W-1:0]     w_sp_dec;
    logic                w_ras_full;
    logic                w_ras_empty;

    // Fetch handshake; address is the PC register itself so it is stable while waiting
    assign imem_req   = (r_state == ST_FETCH) && !stall;
    assign imem_addr  = r_pc;
    assign w_accept   = imem_req && imem_ready;

    assign w_pc_inc    = r_pc + ADDR_W'(1);
    assign w_sp_dec    = r_sp - SP_W'(1);
    assign w_ras_full  = (r_cnt == CNT_W'(RAS_DEPTH));
    assign w_ras_empty = (r_cnt == CNT_W'(0));

    assign pc_out        = r_pc_out;
    assign pc_valid      = r_pc_valid;
    assign ras_overflow  = r_ras_overflow;
    assign ras_underflow = r_ras_underflow;

    // State, PC and flag registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_pc            <= RESET_ADDR;
            r_pc_out        <= RESET_ADDR;
            r_pc_valid      <= 1'b0;
            r_ras_overflow  <= 1'b0;
            r_ras_underflow <= 1'b0;
            r_sp            <= '0;
            r_cnt           <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_pc            <= w_pc_nxt;
            r_pc_out        <= w_pc_out_nxt;
            r_pc_valid      <= w_pc_valid_nxt;
            r_ras_overflow  <= w_ras_overflow_nxt;
            r_ras_underflow <= w_ras_underflow_nxt;
            r_sp            <= w_sp_nxt;
            r_cnt           <= w_cnt_nxt;
        end
    end

    // Return-address storage; a push when full lands on the oldest entry
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                r_ras[i] <= RESET_ADDR;
            end
        end else if (w_push) begin
            r_ras[r_sp] <= w_pc_inc;
        end
    end

    // Next-state and next-PC selection
    always_comb begin
        w_state_nxt         = r_state;
        w_pc_nxt            = r_pc;
        w_pc_out_nxt        = r_pc_out;
        w_pc_valid_nxt      = 1'b0;
        w_ras_overflow_nxt  = r_ras_overflow;
        w_ras_underflow_nxt = r_ras_underflow;
        w_sp_nxt            = r_sp;
        w_cnt_nxt           = r_cnt;
        w_push              = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_FETCH;
            end

            ST_FETCH: begin
                if (halt) begin
                    // Any same-cycle accept is squashed: no pc_valid
                    w_state_nxt = ST_HALTED;
                end else if (redirect_valid) begin
                    // Redirect wins over stall and squashes any accept
                    unique case (redirect_kind)
                        KIND_JUMP: begin
                            w_pc_nxt = redirect_target;
                        end
                        KIND_BRANCH: begin
                            w_pc_nxt = r_pc + redirect_target;
                        end
                        KIND_CALL: begin
                            w_push   = 1'b1;
                            w_sp_nxt = r_sp + SP_W'(1);
                            w_pc_nxt = redirect_target;
                            if (w_ras_full) begin
                                w_ras_overflow_nxt = 1'b1;
                            end else begin
                                w_cnt_nxt = r_cnt + CNT_W'(1);
                            end
                        end
                        KIND_RETURN: begin
                            if (w_ras_empty) begin
                                w_pc_nxt            = RESET_ADDR;
                                w_ras_underflow_nxt = 1'b1;
                            end else begin
                                w_pc_nxt  = r_ras[w_sp_dec];
                                w_sp_nxt  = w_sp_dec;
                                w_cnt_nxt = r_cnt - CNT_W'(1);
                            end
                        end
                        default: begin
                            w_pc_nxt = r_pc;
                        end
                    endcase
                end else if (stall) begin
                    w_pc_nxt = r_pc;
                end else if (w_accept) begin
                    w_pc_nxt       = w_pc_inc;
                    w_pc_out_nxt   = r_pc;
                    w_pc_valid_nxt = 1'b1;
                end
            end

            ST_HALTED: begin
                w_state_nxt = ST_HALTED;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
